// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared owner tags, grant encoding and width defaults for the VRAM arbiter
package vram_arbiter_pkg;

    localparam int AW_DEF       = 16;
    localparam int DW_DEF       = 16;
    localparam int HOST_MAX_DEF = 4;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE = 2'd0;
    localparam tag_t TAG_VID  = 2'd1;
    localparam tag_t TAG_HOST = 2'd2;
    localparam tag_t TAG_BLIT = 2'd3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_HOST = 2'd2,
        GNT_BLIT = 2'd3
    } grant_e;

    // Writes carry no owner: only reads need their data routed back.
    function automatic tag_t read_tag(grant_e g, logic wr);
        tag_t t;
        t = TAG_NONE;
        if (!wr) begin
            case (g)
                GNT_VID:  t = TAG_VID;
                GNT_HOST: t = TAG_HOST;
                GNT_BLIT: t = TAG_BLIT;
                default:  t = TAG_NONE;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester, VRAM and read-return signal bundle for the VRAM arbiter
interface vram_arbiter_if #(
    parameter int AW = vram_arbiter_pkg::AW_DEF,
    parameter int DW = vram_arbiter_pkg::DW_DEF
) ();

    logic          video_ena_i;
    logic          vid_req_i;
    logic [AW-1:0] vid_addr_i;

    logic          host_req_i;
    logic          host_wr_i;
    logic [AW-1:0] host_addr_i;
    logic [DW-1:0] host_data_i;
    logic          host_ack_o;

    logic          blit_req_i;
    logic          blit_wr_i;
    logic [AW-1:0] blit_addr_i;
    logic [DW-1:0] blit_data_i;
    logic          blit_ack_o;

    logic          vram_sel_o;
    logic          vram_wr_o;
    logic [AW-1:0] vram_addr_o;
    logic [DW-1:0] vram_data_o;
    logic [DW-1:0] vram_data_i;

    logic [DW-1:0] rd_data_o;
    logic          vid_rd_valid_o;
    logic          host_rd_valid_o;
    logic          blit_rd_valid_o;

    modport slave (
        input  video_ena_i, vid_req_i, vid_addr_i,
        input  host_req_i, host_wr_i, host_addr_i, host_data_i,
        output host_ack_o,
        input  blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
        output blit_ack_o,
        output vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
        input  vram_data_i,
        output rd_data_o, vid_rd_valid_o, host_rd_valid_o, blit_rd_valid_o
    );

    modport master (
        output video_ena_i, vid_req_i, vid_addr_i,
        output host_req_i, host_wr_i, host_addr_i, host_data_i,
        input  host_ack_o,
        output blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
        input  blit_ack_o,
        input  vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
        output vram_data_i,
        input  rd_data_o, vid_rd_valid_o, host_rd_valid_o, blit_rd_valid_o
    );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// rtl/vram_rd_tag_pipe.sv - two-stage read owner tag pipeline and read-data return demux
module vram_rd_tag_pipe
    import vram_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n_i,
    input  tag_t          tag_in,
    input  logic [DW-1:0] vram_data,
    output logic [DW-1:0] rd_data,
    output logic          vid_valid,
    output logic          host_valid,
    output logic          blit_valid
);

    tag_t stage0;
    tag_t stage1;

    // stage0 lines up with the VRAM strobe, stage1 with the returned data word.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            stage0     <= TAG_NONE;
            stage1     <= TAG_NONE;
            rd_data    <= '0;
            vid_valid  <= 1'b0;
            host_valid <= 1'b0;
            blit_valid <= 1'b0;
        end else begin
            stage0     <= tag_in;
            stage1     <= stage0;
            vid_valid  <= (stage1 == TAG_VID);
            host_valid <= (stage1 == TAG_HOST);
            blit_valid <= (stage1 == TAG_BLIT);
            if (stage1 != TAG_NONE) begin
                rd_data <= vram_data;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter (video > host > blitter); XOSERA_BLIT_FAIR_EN adds blitter anti-starvation
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int HOST_MAX = HOST_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset_n_i,
    vram_arbiter_if.slave bus
);

    grant_e        grant;
    logic          vid_win;
    logic          blit_forced;
    logic          nxt_wr;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_data;
    tag_t          rd_tag;

    assign vid_win = bus.video_ena_i & bus.vid_req_i;

`ifdef XOSERA_BLIT_FAIR_EN
    logic [3:0] host_streak;

    assign blit_forced = bus.blit_req_i && (host_streak >= 4'(HOST_MAX));

    // Counts host wins while the blitter waits; any blitter service or idle blitter resets it.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            host_streak <= '0;
        end else if (!bus.blit_req_i || grant == GNT_BLIT) begin
            host_streak <= '0;
        end else if (grant == GNT_HOST) begin
            host_streak <= host_streak + 4'd1;
        end
    end
`else
    assign blit_forced = 1'b0 && (HOST_MAX > 0);
`endif

    always_comb begin
        grant = GNT_NONE;
        if (vid_win) begin
            grant = GNT_VID;
        end else if (blit_forced) begin
            grant = GNT_BLIT;
        end else if (bus.host_req_i) begin
            grant = GNT_HOST;
        end else if (bus.blit_req_i) begin
            grant = GNT_BLIT;
        end
    end

    // Address and data hold on idle; video has no write data, so data holds there too.
    always_comb begin
        nxt_wr   = 1'b0;
        nxt_addr = bus.vram_addr_o;
        nxt_data = bus.vram_data_o;
        case (grant)
            GNT_VID: begin
                nxt_addr = bus.vid_addr_i;
            end
            GNT_HOST: begin
                nxt_wr   = bus.host_wr_i;
                nxt_addr = bus.host_addr_i;
                nxt_data = bus.host_data_i;
            end
            GNT_BLIT: begin
                nxt_wr   = bus.blit_wr_i;
                nxt_addr = bus.blit_addr_i;
                nxt_data = bus.blit_data_i;
            end
            default: begin
            end
        endcase
    end

    assign rd_tag = read_tag(grant, nxt_wr);

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            bus.vram_sel_o  <= 1'b0;
            bus.vram_wr_o   <= 1'b0;
            bus.vram_addr_o <= '0;
            bus.vram_data_o <= '0;
            bus.host_ack_o  <= 1'b0;
            bus.blit_ack_o  <= 1'b0;
        end else begin
            bus.vram_sel_o  <= (grant != GNT_NONE);
            bus.vram_wr_o   <= nxt_wr;
            bus.vram_addr_o <= nxt_addr;
            bus.vram_data_o <= nxt_data;
            bus.host_ack_o  <= (grant == GNT_HOST);
            bus.blit_ack_o  <= (grant == GNT_BLIT);
        end
    end

    vram_rd_tag_pipe #(
        .DW(DW)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .tag_in     (rd_tag),
        .vram_data  (bus.vram_data_i),
        .rd_data    (bus.rd_data_o),
        .vid_valid  (bus.vid_rd_valid_o),
        .host_valid (bus.host_rd_valid_o),
        .blit_valid (bus.blit_rd_valid_o)
    );

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-port VRAM access arbiter and scheduler shared by three requesters: video fetch, host bus, and the blitter.
- Grants exactly one VRAM access per clock and drives the registered VRAM select/write/address/data strobes.
- Routes returning read data back to the requester that issued the read, with a per-requester valid pulse.
- Replaces the fixed blit-cycle slotting with request/acknowledge handshakes and priority scheduling.

Parameters:
- AW, 16, VRAM address width (word address).
- DW, 16, VRAM data width.
- HOST_MAX, 4, consecutive host wins tolerated before the blitter is forced a slot (optional feature only; 1..15).

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  synchronous active-low reset
- video_ena_i  in  1  video fetch enabled; when 0, vid_req_i is ignored
- vid_req_i  in  1  video read request; valid only on the cycle it is asserted, never held
- vid_addr_i  in  AW  video read address
- host_req_i  in  1  host request; level, held until host_ack_o
- host_wr_i  in  1  host write (1) / read (0)
- host_addr_i  in  AW  host address
- host_data_i  in  DW  host write data
- host_ack_o  out  1  one-cycle pulse: host access issued
- blit_req_i  in  1  blitter request; level, held until blit_ack_o
- blit_wr_i  in  1  blitter write (1) / read (0)
- blit_addr_i  in  AW  blitter address
- blit_data_i  in  DW  blitter write data
- blit_ack_o  out  1  one-cycle pulse: blitter access issued
- vram_sel_o  out  1  VRAM access strobe
- vram_wr_o  out  1  VRAM write enable
- vram_addr_o  out  AW  VRAM address
- vram_data_o  out  DW  VRAM write data
- vram_data_i  in  DW  VRAM read data; valid one cycle after a read strobe
- rd_data_o  out  DW  returned read data (shared by all requesters)
- vid_rd_valid_o  out  1  rd_data_o belongs to video
- host_rd_valid_o  out  1  rd_data_o belongs to host
- blit_rd_valid_o  out  1  rd_data_o belongs to blitter

Behaviour:
- Reset (reset_n_i=0 at a clk edge): all outputs become 0; the in-flight read tag is cleared, so no rd_valid pulse follows a read issued before reset. The fairness counter is cleared.
- Arbitration runs every cycle on cycle-t inputs. Priority:
  - video, if video_ena_i & vid_req_i;
  - else host, if host_req_i;
  - else blitter, if blit_req_i;
  - else idle.
- Grant at t produces registered outputs at t+1:
  - vram_sel_o=1, vram_wr_o = winner's write flag (always 0 for video), vram_addr_o / vram_data_o = winner's values;
  - host_ack_o or blit_ack_o pulses for that winner.
- Idle cycle: vram_sel_o=0, vram_wr_o=0. Address and data hold their last values.
- Read at t: vram_data_i is sampled at t+2, and rd_data_o with the matching *_rd_valid_o is registered at t+3. This is a fixed 3-cycle request-to-data latency. At most one rd_valid is high per cycle.
- Write: no read-back; no rd_valid pulse.
- Pipeline tag: a 2-bit owner code {NONE, VID, HOST, BLIT} travels with each read for two stages. Back-to-back reads from different owners are each routed correctly.
- Handshake rules:
  - The requester must hold req, wr, addr and data stable until ack.
  - req deasserted before ack means the request is withdrawn and no access is issued.
  - A requester may reassert req on the cycle after ack; that request is eligible for a grant the following cycle.
  - Ack and a new grant to the same requester cannot occur in consecutive cycles unless req was re-asserted on the ack cycle.
- Simultaneous events: video always wins. Host and blitter wait with no timeout (without the optional feature, sustained host traffic may starve the blitter).
- video_ena_i falling while a video read is in flight: the read still completes and vid_rd_valid_o still pulses.
- Address/data arithmetic: pass-through only; no wrap or increment.

Optional Feature:
- Macro: XOSERA_BLIT_FAIR_EN.
- With the macro defined:
  - a 4-bit counter increments on each host grant made while blit_req_i=1, and clears on any blitter grant or when blit_req_i=0;
  - when the counter reaches HOST_MAX, the blitter outranks the host for the next non-video slot (video still wins).
- Without the macro: strict priority as above; counter logic absent.

Decomposition:
- Shared package/defs include:
  - owner tag localparams (TAG_NONE=0, TAG_VID=1, TAG_HOST=2, TAG_BLIT=3);
  - AW/DW defaults.
- One natural sub-module, vram_rd_tag_pipe: a 2-stage tag shift register plus output demux producing rd_data_o and the valid pulses. Arbitration stays in the top module.

Test Plan:
- Host write addr 0x0123 data 0x1F20, other requests idle → host_ack_o at t+1 with vram_sel_o=1, vram_wr_o=1, vram_addr_o=0x0123, vram_data_o=0x1F20.
- Video read 0x0040 with VRAM model returning 0xABCD → vid_rd_valid_o=1 and rd_data_o=0xABCD exactly 3 cycles after request; no other valid asserts.
- Video, host and blitter all requesting in the same cycle → order video, then host, then blitter on successive cycles; each ack pulses once.
- Back-to-back host read 0x10 then blitter read 0x20 (model data=addr) → host_rd_valid_o with 0x0010, then blit_rd_valid_o with 0x0020 on the next cycle.
- Host read issued, reset_n_i=0 on the next cycle → all outputs 0; host_rd_valid_o never pulses for that read.
- With XOSERA_BLIT_FAIR_EN and HOST_MAX=4, host and blitter continuously requesting → grants follow the pattern host×4 then blitter×1, repeating; without the macro, the blitter is never granted.
